etc_tile_accum: RTL

ETC_TILE_ACCUM -- requirements
Module: etc_tile_accum

---
 rtl/etc_pkg.sv | 21 ++
 rtl/etc_tile_reduce.sv | 32 +++
 rtl/etc_tile_accum.sv | 110 +++++++++++
 3 files changed

// File: rtl/etc_pkg.sv
// Shared definitions for the tile accumulator: tile geometry, semiring op
// encodings and the controller state type.
package etc_pkg;

    localparam int unsigned TILE_DIM = 4;

    localparam logic [1:0] OP_MMA    = 2'd0;
    localparam logic [1:0] OP_MAXMIN = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Every nonzero encoding selects max-reduce, not just OP_MAXMIN.
    function automatic logic op_is_add(input logic [1:0] op);
        return op == OP_MMA;
    endfunction

endpackage

// File: rtl/etc_tile_reduce.sv
// Element-wise semiring combine of two 4x4 tiles: modular add or unsigned max.
module etc_tile_reduce
    import etc_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [1:0]                                i_op,
    input  logic [TILE_DIM-1:0][TILE_DIM-1:0][W-1:0]  i_acc_tile,
    input  logic [TILE_DIM-1:0][TILE_DIM-1:0][W-1:0]  i_in_tile,
    output logic [TILE_DIM-1:0][TILE_DIM-1:0][W-1:0]  o_nxt_tile
);

    logic w_add;

    assign w_add = op_is_add(i_op);

    always_comb begin
        o_nxt_tile = '0;
        for (int unsigned i = 0; i < TILE_DIM; i++) begin
            for (int unsigned j = 0; j < TILE_DIM; j++) begin
                if (w_add) begin
                    o_nxt_tile[i][j] = i_acc_tile[i][j] + i_in_tile[i][j];
                end else if (i_in_tile[i][j] > i_acc_tile[i][j]) begin
                    o_nxt_tile[i][j] = i_in_tile[i][j];
                end else begin
                    o_nxt_tile[i][j] = i_acc_tile[i][j];
                end
            end
        end
    end

endmodule

// File: rtl/etc_tile_accum.sv
// Reduces num_k partial 4x4 tiles into one accumulator tile and hands the
// result out through a valid/ready handshake.
module etc_tile_accum
    import etc_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned KW = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [1:0]                                op,
    input  logic [KW-1:0]                             num_k,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [TILE_DIM-1:0][TILE_DIM-1:0][W-1:0]  in_tile,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [TILE_DIM-1:0][TILE_DIM-1:0][W-1:0]  out_tile,
    output logic                                      busy
);

    localparam logic [KW-1:0] K_ONE = KW'(1);

    state_t                                    r_state;
    state_t                                    w_state_nxt;
    logic [1:0]                                r_op;
    logic [KW-1:0]                             r_num_k;
    logic [KW-1:0]                             r_count;
    logic [TILE_DIM-1:0][TILE_DIM-1:0][W-1:0]  r_acc;
    logic [TILE_DIM-1:0][TILE_DIM-1:0][W-1:0]  w_reduced;

    logic w_start_ok;
    logic w_accept;
    logic w_last;

    assign w_start_ok = (r_state == ST_IDLE) && start && (num_k != '0);
    assign w_accept   = (r_state == ST_ACCUM) && in_valid;
    assign w_last     = (r_count == (r_num_k - K_ONE));

    etc_tile_reduce #(
        .W (W)
    ) u_reduce (
        .i_op       (r_op),
        .i_acc_tile (r_acc),
        .i_in_tile  (in_tile),
        .o_nxt_tile (w_reduced)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_start_ok) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // count never wraps: the final accept happens at num_k-1, so it peaks at num_k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_num_k <= '0;
            r_count <= '0;
            r_acc   <= '0;
        end else begin
            if (w_start_ok) begin
                r_op    <= op;
                r_num_k <= num_k;
                r_count <= '0;
            end
            if (w_accept) begin
                r_acc   <= (r_count == '0) ? in_tile : w_reduced;
                r_count <= r_count + K_ONE;
            end
        end
    end

    assign out_tile = r_acc;

endmodule
